// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: encodings shared by the main control FSM, ALU control decoder and datapath
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_MEM_ADDR   = 4'd2,
        S_MEM_READ   = 4'd3,
        S_MEM_WB     = 4'd4,
        S_MEM_WRITE  = 4'd5,
        S_EXECUTE    = 4'd6,
        S_R_COMPLETE = 4'd7,
        S_BRANCH     = 4'd8,
        S_JUMP       = 4'd9
    } state_t;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: state-to-control decoder with reset gating and mem_ready qualification
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic       reset,
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       illegal,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state_o,
    output logic       illegal_op
);
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        state_o     = 4'd0;
        illegal_op  = 1'b0;
        if (!reset) begin
            state_o    = state;
            illegal_op = illegal;
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    ALUSrcB = SRCB_FOUR;
                end
                S_DECODE: ALUSrcB = SRCB_IMM_SL2;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_R_COMPLETE: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main sequencing FSM of the multicycle MIPS datapath
module multicycle_main_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state_o,
    output logic       illegal_op
);
    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   op_ok;
    assign op_ok = Op == OP_R || Op == OP_LW || Op == OP_SW || Op == OP_BEQ || Op == OP_J;
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d   = (Op == OP_LW || Op == OP_SW) ? S_MEM_ADDR :
                            Op == OP_R   ? S_EXECUTE :
                            Op == OP_BEQ ? S_BRANCH  :
                            Op == OP_J   ? S_JUMP    : S_FETCH;
                illegal_d = illegal_q | ~op_ok;
            end
            S_MEM_ADDR:  state_d = Op == OP_SW ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_COMPLETE;
            default:     state_d = S_FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end
    mc_ctrl_outdec u_outdec (
        .reset       (reset),
        .state       (state_q),
        .mem_ready   (mem_ready),
        .illegal     (illegal_q),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .state_o     (state_o),
        .illegal_op  (illegal_op)
    );
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: random and directed checks against an instruction-route model
module tb_multicycle_main_control;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [3:0] state_o;
    logic [15:0] outs;
    int total = 0;
    int bad = 0;
    int m_state = 0;
    bit m_ill = 1'b0;
    int route[$];
    logic [63:0] tr;
    logic [15:0] last_outs;
    logic [3:0] last_state;
    logic last_ill;
    int cnt_mw, cnt_rw;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100, JMP = 6'b000010;

    always #5 clk = ~clk;

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

    multicycle_main_control dut (
        .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .state_o(state_o), .illegal_op(illegal_op)
    );

    // Control word each step must show, straight from the per-step output table
    function automatic logic [15:0] want_outs(input int s, input bit mr, input bit rst);
        logic pcw, pcc, iord, mrd, mwr, m2r, irw, srca, rw, rd;
        logic [1:0] pcs, aop, srcb;
        {pcw, pcc, iord, mrd, mwr, m2r, irw, srca, rw, rd} = '0;
        pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
        if (!rst) begin
            case (s)
                0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
                1: srcb = 2'b11;
                2: begin srca = 1; srcb = 2'b10; end
                3: begin mrd = 1; iord = 1; end
                4: begin rw = 1; m2r = 1; end
                5: begin mwr = 1; iord = 1; end
                6: begin srca = 1; aop = 2'b10; end
                7: begin rw = 1; rd = 1; end
                8: begin srca = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
                9: begin pcw = 1; pcs = 2'b10; end
                default: ;
            endcase
        end
        return {pcw, pcc, iord, mrd, mwr, m2r, irw, pcs, aop, srca, srcb, rw, rd};
    endfunction

    task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, g, e);
        end
    endtask

    task automatic trace_is(input string n, input int cnt, input logic [63:0] v);
        chk(n, tr, ({64{1'b1}} << (4 * cnt)) | v);
        tr = '1;
    endtask

    // One clock: drive, compare against the model, then advance the model along the instruction route
    task automatic step(input bit r, input logic [5:0] o, input bit m);
        @(negedge clk);
        reset = r; Op = o; mem_ready = m;
        #1;
        chk("outs", outs, want_outs(m_state, m, r));
        chk("state_o", state_o, r ? 0 : m_state);
        chk("illegal_op", illegal_op, r ? 1'b0 : m_ill);
        tr = {tr[59:0], state_o};
        last_outs = outs; last_state = state_o; last_ill = illegal_op;
        cnt_mw += int'(MemWrite & IorD);
        cnt_rw += int'(RegWrite);
        @(posedge clk);
        if (r) begin
            m_state = 0; m_ill = 0; route.delete();
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !m) begin
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 1) begin
                route.delete();
                case (o)
                    LW:  route = '{2, 3, 4};
                    SW:  route = '{2, 5};
                    RT:  route = '{6, 7};
                    BEQ: route = '{8};
                    JMP: route = '{9};
                    default: m_ill = 1;
                endcase
            end
            m_state = route.size() > 0 ? route.pop_front() : 0;
        end
    endtask

    task automatic run(input logic [5:0] o, input int n, input bit m);
        for (int i = 0; i < n; i++) step(0, o, m);
    endtask

    initial begin
        logic [5:0] rop;
        tr = '1; cnt_mw = 0; cnt_rw = 0;
        for (int i = 0; i < 3; i++) step(1, LW, 1);
        chk("reset_outs", {last_state, last_outs}, 20'h0);
        tr = '1;
        step(0, LW, 1);
        chk("fetch_after_reset", last_outs, 16'h9204);
        run(LW, 4, 1);
        trace_is("lw_trace", 5, 20'h01234);
        cnt_mw = 0; cnt_rw = 0;
        run(SW, 3, 1);
        run(SW, 2, 0);
        run(SW, 1, 1);
        trace_is("sw_trace", 6, 24'h012555);
        chk("sw_memwrite_cycles", cnt_mw, 3);
        chk("sw_no_regwrite", cnt_rw, 0);
        run(RT, 4, 1);
        run(BEQ, 3, 1);
        run(JMP, 3, 1);
        trace_is("r_beq_j_trace", 10, 40'h0167018019);
        chk("jump_outs", last_outs, 16'h8100);
        run(6'b001111, 2, 1);
        step(0, LW, 1);
        chk("illegal_set", last_ill, 1'b1);
        run(LW, 2, 1);
        run(LW, 1, 0);
        trace_is("illegal_trace", 6, 24'h010123);
        chk("memread_wait", last_outs, 16'h3000);
        step(1, LW, 1);
        chk("reset_midread", {last_state, last_outs}, 20'h0);
        step(0, LW, 1);
        chk("after_abort", {last_ill, last_state}, 5'h0);
        rop = LW;
        for (int i = 0; i < 3000; i++) begin
            if (m_state == 0) begin
                case ($urandom_range(0, 5))
                    0: rop = RT;
                    1: rop = LW;
                    2: rop = SW;
                    3: rop = BEQ;
                    4: rop = JMP;
                    default: rop = 6'($urandom_range(0, 63));
                endcase
            end
            step($urandom_range(0, 49) == 0, rop, $urandom_range(0, 9) < 7);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and writeback, and drives every datapath enable and mux select. Its 2-bit ALUOp output is the ALUOp input of the downstream ALU control decoder, which combines it with the funct field to form the 4-bit ALU control. A simple ready handshake stalls the sequence on slow memory accesses.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- reset  input  1  synchronous, active-high reset.
- Op  input  6  opcode field from the instruction register.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- PCWrite  output  1  unconditional PC write enable.
- PCWriteCond  output  1  PC write enable, taken only if the ALU Zero flag is set (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  register write-data select: 0 = ALUOut, 1 = MDR.
- IRWrite  output  1  instruction register load enable.
- PCSource  output  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  feeds ALU control: 00 = add, 01 = subtract, 10 = use funct.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  destination register select: 0 = rt, 1 = rd.
- state_o  output  4  current state encoding, for debug.
- illegal_op  output  1  sticky flag; set when an unsupported opcode is decoded.

## Operation
State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_COMPLETE=7, BRANCH=8, JUMP=9. Encodings 10–15 are unused and recover to FETCH.

Supported opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010.

Outputs are decoded from the state only. The exceptions are qualified by mem_ready, as noted. Any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00, IorD=0. IRWrite=PCWrite=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op: LW or SW → MEM_ADDR, R → EXECUTE, BEQ → BRANCH, J → JUMP. Any other Op → FETCH and set illegal_op.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: R_COMPLETE.
- R_COMPLETE: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.

Op is sampled every cycle. The datapath holds the instruction register stable from DECODE through completion.

## Timing
- Reset: on a clk edge with reset=1, the state goes to FETCH and illegal_op clears.
- While reset is high, all outputs are forced to 0, including state_o=0. This gating is combinational, so nothing is written during reset.
- Reset asserted mid-instruction aborts the instruction. No partial writes occur after the reset edge.
- Cycle counts with mem_ready always 1: LW 5, SW 4, R-type 4, BEQ 3, J 3. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- In a waiting memory state, MemRead, MemWrite and IorD stay constant.
- In FETCH, IRWrite and PCWrite pulse only in the cycle where mem_ready=1.
- mem_ready is ignored in all other states.
- illegal_op is registered. It rises the cycle after DECODE and holds until reset. The FSM keeps executing subsequent instructions.
- If reset and mem_ready are both high in the same cycle, reset wins.

## Structure
- Shared package mc_ctrl_pkg:
  - state enum (4-bit)
  - opcode constants
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - PCSource and ALUSrcB encodings
- The package is also imported by the ALU control decoder and the datapath.
- Sub-module: mc_ctrl_outdec, the combinational state-to-outputs decoder, including reset gating and mem_ready qualification.
- The top level holds the state register, next-state logic and illegal_op.

## Test plan
- Reset held 3 cycles → all outputs 0. After release: state_o=0, MemRead=1, ALUSrcB=01, and IRWrite=PCWrite=1 with mem_ready=1.
- LW (Op=100011), mem_ready=1 → state_o sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- SW with mem_ready low for 2 cycles in MEM_WRITE → MemWrite=1 and IorD=1 held 3 cycles, then FETCH. RegWrite is never 1.
- R-type then BEQ back-to-back → state sequence 0,1,6,7,0,1,8,0. ALUOp=10 in EXECUTE; ALUOp=01 and PCWriteCond=1 in BRANCH.
- J (Op=000010) → state sequence 0,1,9,0, with PCWrite=1 and PCSource=10 in JUMP.
- Op=001111 → DECODE returns to FETCH and illegal_op=1 from the next cycle. Reset asserted mid-MEM_READ → FETCH next edge, with MemRead=0 during the reset cycle.
